store_buffer: RTL and testbench

- Write buffer between the single-cycle core's data-memory port and a slower backing data memory that uses a valid/ready handshake.
- Accepts STUR stores in one cycle and drains them to memory in the background.
- Forwards buffered data to LDUR loads; a load that misses the buffer stalls the core until backing memory returns the data.
- Doubleword (64-bit) accesses only; no byte or halfword support.

---
 rtl/store_buffer_pkg.sv | 16 +
 rtl/sb_entry_array.sv | 74 +++++++
 rtl/store_buffer.sv | 136 +++++++++++++
 tb/tb_store_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared state encoding and default sizes for the store buffer
package store_buffer_pkg;

    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_ADDR_W = 64;
    localparam int DEFAULT_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } sb_state_t;

endpackage

// File: rtl/sb_entry_array.sv
// rtl/sb_entry_array.sv - circular store FIFO with youngest-match forwarding lookup
module sb_entry_array
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] next_addr,
    output logic [DATA_W-1:0] next_data,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head, tail, next_ptr, idx;
    logic              do_push, do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && (count != '0);
    assign next_ptr  = head + PTR_W'(1);
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign next_addr = addr_q[next_ptr];
    assign next_data = data_q[next_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                addr_q[tail] <= push_addr;
                data_q[tail] <= push_data;
                tail         <= tail + PTR_W'(1);
            end
            if (do_pop)
                head <= next_ptr;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write buffer with load forwarding between core and backing memory
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemoryWrite,
    input  logic              MemoryRead,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              empty,
    output logic              mem_req_valid,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_state_t         state;
    logic [DATA_W-1:0] rdata_q;
    logic              hit, full, pop, rd_miss;
    logic [DATA_W-1:0] hit_data, head_data, next_data;
    logic [ADDR_W-1:0] head_addr, next_addr;
    logic [CNT_W-1:0]  count;

    sb_entry_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_entries (
        .clk        (CLK),
        .reset      (reset),
        .push       (MemoryWrite),
        .push_addr  (Address),
        .push_data  (WriteData),
        .pop        (pop),
        .lookup_addr(Address),
        .hit        (hit),
        .hit_data   (hit_data),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .next_addr  (next_addr),
        .next_data  (next_data),
        .full       (full),
        .count      (count)
    );

    // A simultaneous store suppresses the load entirely.
    assign rd_miss = MemoryRead && !MemoryWrite && !hit;
    assign pop     = (state == WR_REQ) && mem_req_ready;
    assign empty   = (count == '0) && (state == IDLE);

    always_comb begin
        Stall    = 1'b0;
        ReadData = rdata_q;
        case (state)
            IDLE, WR_REQ: begin
                Stall = rd_miss || (MemoryWrite && full);
                if (MemoryRead && !MemoryWrite && hit)
                    ReadData = hit_data;
            end
            RD_REQ, RD_WAIT: Stall = 1'b1;
            default:         Stall = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            rdata_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_miss) begin
                        state         <= RD_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= Address;
                    end else if (count != '0) begin
                        state         <= WR_REQ;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= head_addr;
                        mem_req_wdata <= head_data;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        if (rd_miss) begin
                            state         <= RD_REQ;
                            mem_req_write <= 1'b0;
                            mem_req_addr  <= Address;
                        end else if (count > CNT_W'(1)) begin
                            mem_req_addr  <= next_addr;
                            mem_req_wdata <= next_data;
                        end else begin
                            state         <= IDLE;
                            mem_req_valid <= 1'b0;
                            mem_req_write <= 1'b0;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        state         <= RD_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q <= mem_rsp_rdata;
                        state   <= RD_DONE;
                    end
                end
                RD_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed vector bench for store_buffer
module tb_store_buffer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemoryWrite, MemoryRead;
    logic [63:0] Address, WriteData, ReadData;
    logic        Stall, empty;
    logic        mem_req_valid, mem_req_write;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_ready, mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;

    int total  = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    store_buffer dut (
        .CLK          (CLK),
        .reset        (reset),
        .MemoryWrite  (MemoryWrite),
        .MemoryRead   (MemoryRead),
        .Address      (Address),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .empty        (empty),
        .mem_req_valid(mem_req_valid),
        .mem_req_write(mem_req_write),
        .mem_req_addr (mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    typedef struct {
        logic        mw;
        logic        mr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_stall;
        logic [63:0] exp_rdata;
        logic        exp_empty;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance to just after the next rising edge, then drive.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic mw, input logic mr, input logic [63:0] a, input logic [63:0] d);
        MemoryWrite = mw;
        MemoryRead  = mr;
        Address     = a;
        WriteData   = d;
        #2;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 64'h0,  64'h0,    1'b0, 64'h0,    1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 64'h10, 64'hAAAA, 1'b0, 64'h0,    1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 64'h10, 64'h0,    1'b0, 64'hAAAA, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 64'h20, 64'h1,    1'b0, 64'h0,    1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 64'h20, 64'h2,    1'b0, 64'h0,    1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 64'h20, 64'h0,    1'b0, 64'h2,    1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 64'h10, 64'h0,    1'b0, 64'hAAAA, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 64'h30, 64'h3,    1'b0, 64'h0,    1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 64'h38, 64'h5,    1'b1, 64'h0,    1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 64'h30, 64'h0,    1'b0, 64'h3,    1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 64'h10, 64'h9,    1'b1, 64'h0,    1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 64'h20, 64'h0,    1'b0, 64'h2,    1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 64'h99, 64'h0,    1'b1, 64'h0,    1'b0, 1'b1};

        reset = 1'b1;
        MemoryWrite = 0; MemoryRead = 0; Address = 0; WriteData = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        next_cycle();
        next_cycle();
        #2;
        check("rst_stall", 64'(Stall), 64'h0);
        check("rst_empty", 64'(empty), 64'h1);
        check("rst_valid", 64'(mem_req_valid), 64'h0);
        check("rst_write", 64'(mem_req_write), 64'h0);
        check("rst_addr", mem_req_addr, 64'h0);
        check("rst_wdata", mem_req_wdata, 64'h0);
        check("rst_rdata", ReadData, 64'h0);
        reset = 1'b0;

        // Forwarding and full-stall vectors with backing memory held not-ready.
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_stall", i), 64'(Stall), 64'(vecs[i].exp_stall));
            check($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].exp_empty));
            check($sformatf("v%0d_valid", i), 64'(mem_req_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].mr && !vecs[i].mw && !vecs[i].exp_stall)
                check($sformatf("v%0d_rdata", i), ReadData, vecs[i].exp_rdata);
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_waddr", i), mem_req_addr, 64'h10);
        end

        // Drain in order; the blocked 5th store enters the cycle after the first pop.
        next_cycle();
        mem_req_ready = 1'b1;
        drive(1'b1, 1'b0, 64'h38, 64'h5);
        check("dA_stall", 64'(Stall), 64'h1);
        check("dA_addr", mem_req_addr, 64'h10);
        check("dA_wdata", mem_req_wdata, 64'hAAAA);
        check("dA_write", 64'(mem_req_write), 64'h1);
        next_cycle();
        drive(1'b1, 1'b0, 64'h38, 64'h5);
        check("dB_stall", 64'(Stall), 64'h0);
        check("dB_addr", mem_req_addr, 64'h20);
        check("dB_wdata", mem_req_wdata, 64'h1);
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        check("dC_addr", mem_req_addr, 64'h20);
        check("dC_wdata", mem_req_wdata, 64'h2);
        next_cycle();
        #2;
        check("dD_addr", mem_req_addr, 64'h30);
        check("dD_wdata", mem_req_wdata, 64'h3);
        next_cycle();
        #2;
        check("dE_addr", mem_req_addr, 64'h38);
        check("dE_wdata", mem_req_wdata, 64'h5);
        check("dE_valid", 64'(mem_req_valid), 64'h1);
        next_cycle();
        mem_req_ready = 1'b0;
        #2;
        check("dF_valid", 64'(mem_req_valid), 64'h0);
        check("dF_empty", 64'(empty), 64'h1);

        // Load miss with a three-cycle response.
        next_cycle();
        drive(1'b0, 1'b1, 64'h40, 64'h0);
        check("m_idle_stall", 64'(Stall), 64'h1);
        check("m_idle_valid", 64'(mem_req_valid), 64'h0);
        next_cycle();
        mem_req_ready = 1'b1;
        #2;
        check("m_req_stall", 64'(Stall), 64'h1);
        check("m_req_valid", 64'(mem_req_valid), 64'h1);
        check("m_req_write", 64'(mem_req_write), 64'h0);
        check("m_req_addr", mem_req_addr, 64'h40);
        next_cycle();
        mem_req_ready = 1'b0;
        #2;
        check("m_wait1_stall", 64'(Stall), 64'h1);
        check("m_wait1_valid", 64'(mem_req_valid), 64'h0);
        next_cycle();
        #2;
        check("m_wait2_stall", 64'(Stall), 64'h1);
        next_cycle();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hBEEF;
        #2;
        check("m_wait3_stall", 64'(Stall), 64'h1);
        next_cycle();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'h0;
        #2;
        check("m_done_stall", 64'(Stall), 64'h0);
        check("m_done_rdata", ReadData, 64'hBEEF);
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        check("m_after_empty", 64'(empty), 64'h1);

        // Load miss arriving while a drain write waits for ready.
        next_cycle();
        drive(1'b1, 1'b0, 64'h50, 64'h7);
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        next_cycle();
        drive(1'b0, 1'b1, 64'h60, 64'h0);
        check("w_stall", 64'(Stall), 64'h1);
        check("w_write", 64'(mem_req_write), 64'h1);
        check("w_addr", mem_req_addr, 64'h50);
        next_cycle();
        mem_req_ready = 1'b1;
        #2;
        check("w_hold_addr", mem_req_addr, 64'h50);
        check("w_hold_write", 64'(mem_req_write), 64'h1);
        next_cycle();
        #2;
        check("w_rd_valid", 64'(mem_req_valid), 64'h1);
        check("w_rd_write", 64'(mem_req_write), 64'h0);
        check("w_rd_addr", mem_req_addr, 64'h60);
        check("w_rd_stall", 64'(Stall), 64'h1);
        next_cycle();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h1234;
        #2;
        check("w_wait_stall", 64'(Stall), 64'h1);
        next_cycle();
        mem_rsp_valid = 1'b0;
        #2;
        check("w_done_rdata", ReadData, 64'h1234);
        check("w_done_stall", 64'(Stall), 64'h0);
        next_cycle();
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        check("w_after_empty", 64'(empty), 64'h1);

        // Reset during RD_WAIT abandons the read; a late response is ignored.
        next_cycle();
        drive(1'b0, 1'b1, 64'h70, 64'h0);
        next_cycle();
        mem_req_ready = 1'b1;
        next_cycle();
        mem_req_ready = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hDEAD;
        #2;
        check("r_stall", 64'(Stall), 64'h0);
        check("r_empty", 64'(empty), 64'h1);
        check("r_valid", 64'(mem_req_valid), 64'h0);
        next_cycle();
        mem_rsp_valid = 1'b0;
        #2;
        check("r_rdata", ReadData, 64'h0);
        check("r_empty2", 64'(empty), 64'h1);
        check("r_stall2", 64'(Stall), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
